// File: rtl/alu_issue.sv
// Single-transaction ALU issue stage: latches a PHV/action pair, issues operands
// to an external ALU, merges the result into the dest container, then hands the PHV on.
module alu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int ACTION_LEN = 64,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
  input  logic [ACTION_LEN-1:0]          action_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ACTION_LEN-1:0]          alu_action,
  output logic                           alu_action_valid,
  output logic [DATA_WIDTH-1:0]          alu_op1,
  output logic [DATA_WIDTH-1:0]          alu_op2,
  output logic [DATA_WIDTH-1:0]          alu_op3,
  input  logic                           alu_ready,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           alu_result_valid,
  output logic                           alu_result_ready,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic                           timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  typedef struct packed {
    logic [2:0]  dest;
    logic [3:0]  opc;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic [14:0] imm;
  } dec_t;

  state_t                               state, state_nxt;
  logic [CW-1:0]                        cnt;
  logic [NUM_CONT-1:0][DATA_WIDTH-1:0]  cont_q;
  logic [ACTION_LEN-1:0]                act_q;
  dec_t                                 dec;
  logic                                 acc, capture;

  assign dec = '{dest: act_q[29:27], opc: act_q[24:21], op1: act_q[20:18],
                 op2: act_q[17:15], imm: act_q[14:0]};

  function automatic logic [DATA_WIDTH-1:0] pick(
    input logic [NUM_CONT-1:0][DATA_WIDTH-1:0] c,
    input logic [2:0]                          idx
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CONT; i++)
      if (int'(idx) == i) r = c[i];
    return r;
  endfunction

  // Immediate forms: any opcode with bit 3 set, plus 0111.
  logic use_imm;
  assign use_imm = dec.opc[3] || (dec.opc == 4'b0111);

  assign alu_action = act_q;
  assign alu_op1    = pick(cont_q, dec.op1);
  assign alu_op2    = use_imm ? DATA_WIDTH'(dec.imm) : pick(cont_q, dec.op2);
  assign alu_op3    = pick(cont_q, dec.dest);
  assign phv_out    = cont_q;

  assign acc     = (state == IDLE) && in_valid && !rst;
  assign capture = (state == WAIT) && alu_result_valid && !rst;

  always_comb begin
    state_nxt        = state;
    in_ready         = 1'b0;
    alu_action_valid = 1'b0;
    alu_result_ready = 1'b0;
    phv_out_valid    = 1'b0;
    timeout_err      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (action_in[24:21] == 4'b0000) ? OUT : ISSUE;
      end
      ISSUE: begin
        alu_action_valid = alu_ready;
        if (alu_ready) state_nxt = WAIT;
      end
      WAIT: begin
        alu_result_ready = 1'b1;
        if (alu_result_valid) begin
          state_nxt = OUT;
        end else if (cnt == TMO_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = OUT;
        end
      end
      OUT: begin
        phv_out_valid = 1'b1;
        if (phv_out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset overrides outputs combinationally so the reset cycle itself looks idle.
    if (rst) begin
      state_nxt        = IDLE;
      in_ready         = 1'b1;
      alu_action_valid = 1'b0;
      alu_result_ready = 1'b0;
      phv_out_valid    = 1'b0;
      timeout_err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cont_q <= '0;
      act_q  <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        cont_q <= phv_in;
        act_q  <= action_in;
      end
      if (alu_action_valid)
        cnt <= '0;
      else if ((state == WAIT) && !alu_result_valid)
        cnt <= cnt + 1'b1;
      if (capture)
        for (int i = 0; i < NUM_CONT; i++)
          if (int'(dec.dest) == i) cont_q[i] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: a transaction-level schedule model sets the
// expected outputs for every cycle and one negedge process compares them.
module tb_alu_issue;
  localparam int DW = 32, NC = 8, AL = 64, TO = 16, PW = DW*NC;

  logic          clk = 1'b0, rst = 1'b1;
  logic [PW-1:0] phv_in, phv_out;
  logic [AL-1:0] action_in, alu_action;
  logic          in_valid, in_ready, alu_action_valid, alu_ready;
  logic [DW-1:0] alu_op1, alu_op2, alu_op3, alu_result;
  logic          alu_result_valid, alu_result_ready, phv_out_valid, phv_out_ready, timeout_err;

  always #5 clk = ~clk;

  alu_issue #(.DATA_WIDTH(DW), .NUM_CONT(NC), .ACTION_LEN(AL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .phv_in(phv_in), .action_in(action_in), .in_valid(in_valid),
    .in_ready(in_ready), .alu_action(alu_action), .alu_action_valid(alu_action_valid),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3), .alu_ready(alu_ready),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .alu_result_ready(alu_result_ready), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready), .timeout_err(timeout_err));

  int checks = 0, errors = 0, cyc = 0;
  logic          e_in_ready, e_av, e_rr, e_ov, e_to;
  logic [AL-1:0] e_act;
  logic [DW-1:0] e_op1, e_op2, e_op3;
  logic [PW-1:0] e_phv;

  logic [DW-1:0] l_op1, l_op2;
  logic [PW-1:0] l_phv;
  int            acc_cyc, iss_cyc, ov_cyc, to_cyc, av_cnt;
  logic          prev_ov = 1'b0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    chk("in_ready", in_ready, e_in_ready);
    chk("alu_action_valid", alu_action_valid, e_av);
    chk("alu_result_ready", alu_result_ready, e_rr);
    chk("phv_out_valid", phv_out_valid, e_ov);
    chk("timeout_err", timeout_err, e_to);
    if (e_av) begin
      chk("alu_action", alu_action, e_act);
      chk("alu_op1", alu_op1, e_op1);
      chk("alu_op2", alu_op2, e_op2);
      chk("alu_op3", alu_op3, e_op3);
    end
    if (e_ov) chk("phv_out", phv_out, e_phv);
    if (in_valid && in_ready) acc_cyc = cyc;
    if (alu_action_valid) begin
      iss_cyc = cyc; av_cnt++; l_op1 = alu_op1; l_op2 = alu_op2;
    end
    if (phv_out_valid && !prev_ov) ov_cyc = cyc;
    if (phv_out_valid) l_phv = phv_out;
    if (timeout_err) to_cyc = cyc;
    prev_ov = phv_out_valid;
  end

  function automatic logic [DW-1:0] cont(input logic [PW-1:0] p, input int i);
    return p[i*DW +: DW];
  endfunction

  function automatic logic [AL-1:0] mk_act(input int dest, input int opc, input int o1,
                                           input int o2, input int imm);
    logic [AL-1:0] a;
    a = {$urandom, $urandom};
    a[29:27] = 3'(dest); a[24:21] = 4'(opc); a[20:18] = 3'(o1);
    a[17:15] = 3'(o2);   a[14:0]  = 15'(imm);
    return a;
  endfunction

  function automatic logic [PW-1:0] rnd_phv();
    logic [PW-1:0] p;
    for (int i = 0; i < NC; i++) p[i*DW +: DW] = $urandom;
    return p;
  endfunction

  task automatic step(); @(posedge clk); #1; endtask
  task automatic exp_clr(); e_in_ready = 0; e_av = 0; e_rr = 0; e_ov = 0; e_to = 0; endtask
  task automatic exp_idle(); exp_clr(); e_in_ready = 1; endtask

  // Garbage on inputs the DUT must ignore in the current state.
  task automatic noise();
    in_valid = 1'($urandom); phv_in = rnd_phv(); action_in = {$urandom, $urandom};
    alu_result = $urandom; phv_out_ready = 1'($urandom);
  endtask

  // One transaction; res_dly<0 means the ALU never answers, rst_w>=0 resets in that WAIT cycle.
  task automatic txn(input logic [PW-1:0] p, input logic [AL-1:0] a, input int rdy_dly,
                     input int res_dly, input logic [DW-1:0] res, input int out_dly,
                     input int rst_w);
    logic [PW-1:0] ph;
    int dest, opc;
    dest = int'(a[29:27]); opc = int'(a[24:21]); ph = p;
    exp_idle();
    in_valid = 1; phv_in = p; action_in = a; alu_ready = 1'($urandom);
    alu_result_valid = 1'($urandom); alu_result = $urandom;
    step();
    if (opc != 0) begin
      for (int i = 0; i < rdy_dly; i++) begin
        exp_clr(); noise(); alu_ready = 0; alu_result_valid = 1'($urandom); step();
      end
      exp_clr(); noise(); alu_ready = 1; alu_result_valid = 1'($urandom);
      e_av = 1; e_act = a; e_op1 = cont(p, int'(a[20:18])); e_op3 = cont(p, dest);
      e_op2 = (a[24] || a[24:21] == 4'b0111) ? DW'(a[14:0]) : cont(p, int'(a[17:15]));
      step();
      for (int w = 0; ; w++) begin
        exp_clr(); noise(); alu_ready = 1'($urandom); e_rr = 1; alu_result_valid = 0;
        if (w == rst_w) begin
          rst = 1; exp_idle(); step(); rst = 0;
          exp_idle(); in_valid = 0; alu_result_valid = 1; step();
          alu_result_valid = 0;
          return;
        end
        if (w == res_dly) begin
          alu_result_valid = 1; alu_result = res; ph[dest*DW +: DW] = res; step(); break;
        end
        if (w == TO-1) begin e_to = 1; step(); break; end
        step();
      end
    end
    for (int i = 0; i <= out_dly; i++) begin
      exp_clr(); noise(); alu_result_valid = 1'($urandom); e_ov = 1; e_phv = ph;
      phv_out_ready = (i == out_dly); step();
    end
    exp_idle(); in_valid = 0; alu_result_valid = 1'($urandom); phv_out_ready = 0;
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [AL-1:0] a;
    in_valid = 0; phv_in = '0; action_in = '0; alu_ready = 0; alu_result = '0;
    alu_result_valid = 0; phv_out_ready = 0;
    exp_idle();
    repeat (3) step();
    rst = 0;
    step();

    // add: c2=5, c3=7, dest 4, ALU returns 12
    for (int i = 0; i < NC; i++) p[i*DW +: DW] = DW'(100 + i);
    p[2*DW +: DW] = 5; p[3*DW +: DW] = 7;
    a = mk_act(4, 1, 2, 3, 0);
    av_cnt = 0;
    txn(p, a, 0, 0, 12, 0, -1);
    chk("add_op1", l_op1, 5);
    chk("add_op2", l_op2, 7);
    chk("add_dest", cont(l_phv, 4), 12);
    chk("add_c0_kept", cont(l_phv, 0), 100);
    chk("add_c3_kept", cont(l_phv, 3), 7);
    chk("alu_issue_lat", iss_cyc - acc_cyc, 1);
    chk("alu_out_lat", ov_cyc - acc_cyc, 3);
    chk("add_one_issue", av_cnt, 1);
    step();

    // addi with imm 0x10 and alu_ready low for 3 cycles
    av_cnt = 0;
    txn(p, mk_act(1, 9, 0, 5, 16'h0010), 3, 0, 32'hdead, 0, -1);
    chk("addi_op2", l_op2, 16);
    chk("ready_stall_issue", iss_cyc - acc_cyc, 4);
    chk("ready_stall_once", av_cnt, 1);

    // bypass, held downstream for 5 cycles
    av_cnt = 0;
    txn(p, mk_act(6, 0, 1, 2, 3), 0, 0, 0, 5, -1);
    chk("bypass_lat", ov_cyc - acc_cyc, 1);
    chk("bypass_no_issue", av_cnt, 0);
    chk("bypass_c6", cont(l_phv, 6), 106);

    // timeout
    txn(p, mk_act(5, 2, 1, 2, 0), 0, -1, 0, 1, -1);
    chk("timeout_dist", to_cyc - iss_cyc, 16);
    chk("timeout_c5_kept", cont(l_phv, 5), 105);

    // reset in WAIT, then a normal bypass must work
    txn(p, mk_act(3, 4, 1, 2, 0), 1, -1, 0, 0, 3);
    txn(rnd_phv(), mk_act(0, 0, 0, 0, 0), 0, 0, 0, 0, -1);

    for (int t = 0; t < 300; t++) begin
      int opc, rd;
      opc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      rd  = ($urandom_range(0, 7) == 0) ? -1 :
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO-1) : $urandom_range(0, 2);
      txn(rnd_phv(), mk_act($urandom_range(0, 7), opc, $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 32767)),
          $urandom_range(0, 3), rd, $urandom, $urandom_range(0, 3),
          ($urandom_range(0, 29) == 0) ? $urandom_range(0, 3) : -1);
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
